seg_scan_ctrl: RTL and testbench

Time-multiplexed refresh controller for the 4-digit seven-segment display path.
- Sits directly upstream of the 4:1 digit mux / segment decoder / enable demux stage.
- Holds double-buffered digit values q0..q3 that feed the mux data inputs.
- Generates the mux select `sel` and the one-hot digit enables, with blanking gaps between digits to prevent ghosting.

---
 rtl/seg_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Refresh scanner for the 4-digit seven-segment path: drives mux select and one-hot
// digit enables with blanking gaps, and double-buffers the displayed digit values.
module seg_scan_ctrl #(
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_mask,
  input  logic       upd,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic [1:0] sel,
  output logic [3:0] dig_en,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

  // First set bit of mask, searching cyclically upward from start.
  function automatic logic [1:0] first_from(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    res = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      res = mask[idx] ? idx : res;
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [1:0]       sel_r, sel_nx_s;
  logic [1:0]       next_idx_s;
  logic [3:0]       dig_en_r, dig_en_nx_s;
  logic             boundary_s;
  logic [15:0]      q_r, q_nx_s;
  logic [15:0]      pend_r, pend_nx_s;
  logic             pend_flag_r, pend_flag_nx_s;
  logic             tick_r, tick_nx_s;

  // Scan sequencing: state, dwell/blank counter and next-digit selection.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    sel_nx_s   = sel_r;
    boundary_s = 1'b0;
    next_idx_s = first_from(digit_mask, sel_r + 2'd1);
    if (!en) begin
      state_nx_s = ST_IDLE;
      cnt_nx_s   = '0;
      sel_nx_s   = 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_nx_s = '0;
          if (|digit_mask) begin
            state_nx_s = ST_BLANK;
            sel_nx_s   = first_from(digit_mask, 2'd0);
          end else begin
            state_nx_s = ST_IDLE;
            sel_nx_s   = 2'd0;
          end
        end
        ST_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_nx_s = ST_SHOW;
            cnt_nx_s   = '0;
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_r == DWELL_LAST) begin
            cnt_nx_s = '0;
            // Wrap (next <= current, single digit included) marks the frame boundary.
            if (|digit_mask) begin
              state_nx_s = ST_BLANK;
              sel_nx_s   = next_idx_s;
              boundary_s = (next_idx_s <= sel_r);
            end else begin
              state_nx_s = ST_IDLE;
              sel_nx_s   = 2'd0;
            end
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = '0;
          sel_nx_s   = 2'd0;
        end
      endcase
    end
    dig_en_nx_s = (state_nx_s == ST_SHOW) ? onehot(sel_nx_s) : 4'b0000;
  end

  // Double buffer: pending capture on upd, transfer to display only at a frame boundary.
  always_comb begin
    q_nx_s         = q_r;
    pend_nx_s      = pend_r;
    pend_flag_nx_s = pend_flag_r;
    tick_nx_s      = 1'b0;
    if (boundary_s) begin
      if (upd) begin
        q_nx_s         = {d3, d2, d1, d0};
        pend_flag_nx_s = 1'b0;
        tick_nx_s      = 1'b1;
      end else if (pend_flag_r) begin
        q_nx_s         = pend_r;
        pend_flag_nx_s = 1'b0;
        tick_nx_s      = 1'b1;
      end else begin
        tick_nx_s = 1'b0;
      end
    end else if (upd) begin
      pend_nx_s      = {d3, d2, d1, d0};
      pend_flag_nx_s = 1'b1;
    end else begin
      pend_flag_nx_s = pend_flag_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      sel_r       <= 2'd0;
      dig_en_r    <= 4'b0000;
      q_r         <= 16'h0000;
      pend_r      <= 16'h0000;
      pend_flag_r <= 1'b0;
      tick_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      sel_r       <= sel_nx_s;
      dig_en_r    <= dig_en_nx_s;
      q_r         <= q_nx_s;
      pend_r      <= pend_nx_s;
      pend_flag_r <= pend_flag_nx_s;
      tick_r      <= tick_nx_s;
    end
  end

  assign q0         = q_r[3:0];
  assign q1         = q_r[7:4];
  assign q2         = q_r[11:8];
  assign q3         = q_r[15:12];
  assign sel        = sel_r;
  assign dig_en     = dig_en_r;
  assign frame_tick = tick_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DWELL=4, BLANK=2 (6-cycle digit period).
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] digit_mask;
  logic       upd;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] q0, q1, q2, q3;
  logic [1:0] sel;
  logic [3:0] dig_en;
  logic       frame_tick;

  int n_cmp;
  int n_err;

  seg_scan_ctrl #(.DWELL(4), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(digit_mask), .upd(upd),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .sel(sel), .dig_en(dig_en), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_upd(input logic [15:0] v);
    upd = 1'b1;
    {d3, d2, d1, d0} = v;
  endtask

  // n counts edges since the IDLE->BLANK edge; digit slot k lasts 6 cycles: 2 blank, 4 shown.
  task automatic chk_scan(input string ph, input int n, input logic [7:0] order, input int len,
                          input logic [15:0] exp_q, input logic exp_tick);
    int k;
    int p;
    logic [7:0] ord;
    logic [1:0] dig;
    k   = ((n - 1) / 6) % len;
    p   = (n - 1) % 6;
    ord = order >> (2 * k);
    dig = ord[1:0];
    check_val($sformatf("%s n=%0d sel", ph, n), 32'(sel), 32'(dig));
    check_val($sformatf("%s n=%0d dig_en", ph, n), 32'(dig_en),
              (p < 2) ? 32'd0 : (32'd1 << dig));
    check_val($sformatf("%s n=%0d q", ph, n), 32'({q3, q2, q1, q0}), 32'(exp_q));
    check_val($sformatf("%s n=%0d tick", ph, n), 32'(frame_tick), 32'(exp_tick));
  endtask

  initial begin
    logic [15:0] eq;
    n_cmp = 0;
    n_err = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    en = 1'b1;
    digit_mask = 4'b1111;
    upd = 1'b0;
    {d3, d2, d1, d0} = 16'h0000;

    // Reset held 3 cycles with en high.
    repeat (3) step();
    check_val("rst sel", 32'(sel), 32'd0);
    check_val("rst dig_en", 32'(dig_en), 32'd0);
    check_val("rst q", 32'({q3, q2, q1, q0}), 32'd0);
    check_val("rst tick", 32'(frame_tick), 32'd0);

    rst_n = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_val($sformatf("idle%0d dig_en", i), 32'(dig_en), 32'd0);
      check_val($sformatf("idle%0d sel", i), 32'(sel), 32'd0);
    end

    // Full scan with double-buffer overwrite and an upd on the exact boundary edge.
    en = 1'b1;
    for (int n = 1; n <= 88; n++) begin
      step();
      upd = 1'b0;
      eq = (n < 25) ? 16'h0000 : ((n < 49) ? 16'h8765 : 16'hCBA9);
      chk_scan("full", n, 8'b11_10_01_00, 4, eq, (n == 25) || (n == 49));
      if (n == 9)  drive_upd(16'h4321);
      if (n == 15) drive_upd(16'h8765);
      if (n == 48) drive_upd(16'hCBA9);
    end

    // en dropped during digit-2 dwell, then re-enabled.
    en = 1'b0;
    step();
    check_val("endrop dig_en", 32'(dig_en), 32'd0);
    check_val("endrop sel", 32'(sel), 32'd0);
    check_val("endrop q", 32'({q3, q2, q1, q0}), 32'hCBA9);
    en = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      chk_scan("reen", n, 8'b11_10_01_00, 4, 16'hCBA9, 1'b0);
    end

    // Sparse mask 1010: digits 1 and 3 alternate, wrap 3->1 is the boundary.
    en = 1'b0;
    step();
    digit_mask = 4'b1010;
    en = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      upd = 1'b0;
      chk_scan("sparse", n, 8'b00_00_11_01, 2, (n < 13) ? 16'hCBA9 : 16'h4321, n == 13);
      if (n == 10) drive_upd(16'h4321);
    end

    // Single digit 2: every SHOW->BLANK is a boundary.
    en = 1'b0;
    step();
    digit_mask = 4'b0100;
    en = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      step();
      upd = 1'b0;
      chk_scan("single", n, 8'b00_00_00_10, 1, (n < 7) ? 16'h4321 : 16'h5555, n == 7);
      if (n == 3) drive_upd(16'h5555);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
